// File: rtl/tma_event_counter.sv
// TMA event counter unit: per-slot decode/retire event accumulation with a registered read port.
// Optional registered derived metrics (addresses 8-11) are built when TMA_DERIVED_EN is defined.
module tma_event_counter #(
    parameter int CNT_W         = 64,
    parameter int FLUSH_PENALTY = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             halt_i,
    input  logic             dec0_vld_i,
    input  logic             dec1_vld_i,
    input  logic             backend_stall_i,
    input  logic             flush_i,
    input  logic             retire0_i,
    input  logic             retire1_i,
    input  logic             rd_en_i,
    input  logic [3:0]       rd_addr_i,
    output logic [CNT_W-1:0] rd_data_o,
    output logic             rd_vld_o,
    output logic             frozen_o
);

    typedef enum logic [1:0] {IDLE, COUNT, FROZEN} state_t;

    localparam int A_CYC = 0;
    localparam int A_SLT = 1;
    localparam int A_INS = 2;
    localparam int A_BUB = 3;
    localparam int A_FE  = 4;
    localparam int A_BE  = 5;
    localparam int A_RET = 6;
    localparam int A_FLU = 7;

    state_t           state;
    logic [CNT_W-1:0] cnt [8];
    logic [1:0]       inc [8];
    logic [1:0]       n_dec;
    logic [CNT_W-1:0] rd_mux;

    // Increment of 0..2 that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign n_dec = {1'b0, dec0_vld_i} + {1'b0, dec1_vld_i};

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        for (int i = 0; i < 8; i++) inc[i] = 2'd0;
        if (state == COUNT) begin
            inc[A_CYC] = 2'd1;
            inc[A_SLT] = 2'd2;
            inc[A_INS] = n_dec;
            inc[A_BUB] = 2'd2 - n_dec;
            if (backend_stall_i) inc[A_BE] = n_dec;
            else                 inc[A_FE] = n_dec;
            inc[A_RET] = {1'b0, retire0_i} + {1'b0, retire1_i};
            inc[A_FLU] = {1'b0, flush_i};
        end
    end

    // NOTE: state and counters use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            frozen_o <= 1'b0;
        end else if (clr_i) begin
            state    <= IDLE;
            frozen_o <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (en_i) state <= COUNT;
                COUNT:   if (halt_i) begin
                             state    <= FROZEN;
                             frozen_o <= 1'b1;
                         end
                default: state <= state;
            endcase
        end
    end

    // NOTE: the counter array is a bank of flops, not a RAM, so it is reset like any other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) cnt[i] <= sat_add(cnt[i], inc[i]);
        end
    end

`ifdef TMA_DERIVED_EN
    logic [CNT_W-1:0] flush_rec_c;
    logic [CNT_W-1:0] flush_rec_q;
    logic [CNT_W-1:0] fe_bound_q;
    logic [CNT_W-1:0] bad_spec_q;
    logic [CNT_W-1:0] retired_q;

    assign flush_rec_c = cnt[A_FLU] * CNT_W'(2 * FLUSH_PENALTY);

    // Derived metrics are all computed from the same counter snapshot, one cycle behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_rec_q <= '0;
            fe_bound_q  <= '0;
            bad_spec_q  <= '0;
            retired_q   <= '0;
        end else if (clr_i) begin
            flush_rec_q <= '0;
            fe_bound_q  <= '0;
            bad_spec_q  <= '0;
            retired_q   <= '0;
        end else begin
            flush_rec_q <= flush_rec_c;
            fe_bound_q  <= (cnt[A_FE] > flush_rec_c) ? cnt[A_FE] - flush_rec_c : '0;
            bad_spec_q  <= (cnt[A_INS] > cnt[A_RET]) ? cnt[A_INS] - cnt[A_RET] : '0;
            retired_q   <= cnt[A_RET];
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        if (!rd_addr_i[3]) begin
            rd_mux = cnt[rd_addr_i[2:0]];
        end
`ifdef TMA_DERIVED_EN
        else begin
            case (rd_addr_i[2:0])
                3'd0:    rd_mux = flush_rec_q;
                3'd1:    rd_mux = fe_bound_q;
                3'd2:    rd_mux = bad_spec_q;
                3'd3:    rd_mux = retired_q;
                default: rd_mux = '0;
            endcase
        end
`endif
    end

    // Read data holds between requests; a read beside clr_i still sees the pre-clear value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_o  <= 1'b0;
            rd_data_o <= '0;
        end else begin
            rd_vld_o <= rd_en_i;
            if (rd_en_i) rd_data_o <= rd_mux;
        end
    end

endmodule

// File: tb/tb_tma_event_counter.sv
// Directed bench for tma_event_counter (CNT_W=8 so saturation is reachable quickly).
module tb_tma_event_counter;

    localparam int W = 8;

    localparam logic [8:0] D0 = 9'h001;
    localparam logic [8:0] D1 = 9'h002;
    localparam logic [8:0] ST = 9'h004;
    localparam logic [8:0] FL = 9'h008;
    localparam logic [8:0] R0 = 9'h010;
    localparam logic [8:0] R1 = 9'h020;
    localparam logic [8:0] HL = 9'h040;
    localparam logic [8:0] EN = 9'h080;
    localparam logic [8:0] CL = 9'h100;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en_i = 1'b0, clr_i = 1'b0, halt_i = 1'b0;
    logic         dec0_vld_i = 1'b0, dec1_vld_i = 1'b0, backend_stall_i = 1'b0;
    logic         flush_i = 1'b0, retire0_i = 1'b0, retire1_i = 1'b0;
    logic         rd_en_i = 1'b0;
    logic [3:0]   rd_addr_i = 4'd0;
    logic [W-1:0] rd_data_o;
    logic         rd_vld_o;
    logic         frozen_o;

    int errors = 0;
    int checks = 0;

    tma_event_counter #(.CNT_W(W), .FLUSH_PENALTY(4)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .clr_i(clr_i), .halt_i(halt_i),
        .dec0_vld_i(dec0_vld_i), .dec1_vld_i(dec1_vld_i), .backend_stall_i(backend_stall_i),
        .flush_i(flush_i), .retire0_i(retire0_i), .retire1_i(retire1_i),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .rd_vld_o(rd_vld_o), .frozen_o(frozen_o)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; inputs are released 1 time unit after the edge.
    task automatic drive(input logic [8:0] ev, input logic rd, input logic [3:0] ra);
        {clr_i, en_i, halt_i, retire1_i, retire0_i, flush_i, backend_stall_i, dec1_vld_i, dec0_vld_i} = ev;
        rd_en_i = rd;
        rd_addr_i = ra;
        @(posedge clk);
        #1;
        {clr_i, en_i, halt_i, retire1_i, retire0_i, flush_i, backend_stall_i, dec1_vld_i, dec0_vld_i} = '0;
        rd_en_i = 1'b0;
        rd_addr_i = 4'd0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [8:0] ev, output logic [W-1:0] d, output logic v);
        drive(ev, 1'b1, a);
        d = rd_data_o;
        v = rd_vld_o;
    endtask

    task automatic test_reset();
        logic [W-1:0] d;
        logic v;
        #3;
        checks++;
        if (rd_data_o !== '0 || rd_vld_o !== 1'b0 || frozen_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%0d vld=%b frozen=%b expected 0 0 0", rd_data_o, rd_vld_o, frozen_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd(4'd0, '0, d, v);
        checks++;
        if (v !== 1'b1 || d !== 8'd0) begin
            errors++;
            $display("FAIL reset_read_cycles: got %0d (vld %b) expected 0", d, v);
        end
    endtask

    task automatic test_dual();
        logic [W-1:0] d;
        logic v;
        logic [3:0]   addrs [5] = '{4'd2, 4'd4, 4'd1, 4'd3, 4'd0};
        logic [W-1:0] exps  [5] = '{8'd20, 8'd20, 8'd20, 8'd0, 8'd10};
        drive(EN, 1'b0, 4'd0);
        repeat (9) drive(D0 | D1, 1'b0, 4'd0);
        drive(D0 | D1 | HL, 1'b0, 4'd0);
        checks++;
        if (frozen_o !== 1'b1) begin
            errors++;
            $display("FAIL dual_frozen: got %b expected 1", frozen_o);
        end
        for (int i = 0; i < 5; i++) begin
            rd(addrs[i], '0, d, v);
            checks++;
            if (v !== 1'b1 || d !== exps[i]) begin
                errors++;
                $display("FAIL dual_addr%0d: got %0d (vld %b) expected %0d", addrs[i], d, v, exps[i]);
            end
        end
    endtask

    task automatic test_backend();
        logic [W-1:0] d;
        logic v;
        logic [3:0]   addrs [6] = '{4'd5, 4'd3, 4'd2, 4'd1, 4'd4, 4'd0};
        logic [W-1:0] exps  [6] = '{8'd6, 8'd6, 8'd6, 8'd12, 8'd0, 8'd6};
        drive(CL, 1'b0, 4'd0);
        drive(EN, 1'b0, 4'd0);
        repeat (5) drive(D0 | ST, 1'b0, 4'd0);
        drive(D0 | ST | HL, 1'b0, 4'd0);
        for (int i = 0; i < 6; i++) begin
            rd(addrs[i], '0, d, v);
            checks++;
            if (v !== 1'b1 || d !== exps[i]) begin
                errors++;
                $display("FAIL backend_addr%0d: got %0d (vld %b) expected %0d", addrs[i], d, v, exps[i]);
            end
        end
    endtask

    task automatic test_flush_derived();
        logic [W-1:0] d;
        logic v;
        logic [8:0]   ev;
        logic [3:0]   addrs [11] = '{4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd15};
`ifdef TMA_DERIVED_EN
        logic [W-1:0] exps  [11] = '{8'd30, 8'd20, 8'd10, 8'd25, 8'd3, 8'd24, 8'd0, 8'd5, 8'd25, 8'd0, 8'd0};
`else
        logic [W-1:0] exps  [11] = '{8'd30, 8'd20, 8'd10, 8'd25, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
`endif
        drive(CL, 1'b0, 4'd0);
        drive(EN, 1'b0, 4'd0);
        for (int i = 0; i < 15; i++) begin
            ev = D0 | D1;
            if (i < 5)   ev = ev | ST;
            if (i < 3)   ev = ev | FL;
            if (i < 12)  ev = ev | R0 | R1;
            if (i == 12) ev = ev | R0;
            if (i == 14) ev = ev | HL;
            drive(ev, 1'b0, 4'd0);
        end
        for (int i = 0; i < 11; i++) begin
            rd(addrs[i], '0, d, v);
            checks++;
            if (v !== 1'b1 || d !== exps[i]) begin
                errors++;
                $display("FAIL flush_addr%0d: got %0d (vld %b) expected %0d", addrs[i], d, v, exps[i]);
            end
        end
    endtask

    task automatic test_halt();
        logic [W-1:0] d;
        logic v;
        logic [3:0]   addrs [4] = '{4'd2, 4'd0, 4'd6, 4'd3};
        logic [W-1:0] exps  [4] = '{8'd3, 8'd3, 8'd0, 8'd3};
        drive(CL, 1'b0, 4'd0);
        drive(EN, 1'b0, 4'd0);
        drive(D0, 1'b0, 4'd0);
        drive(D0, 1'b0, 4'd0);
        drive(D0 | HL, 1'b0, 4'd0);
        checks++;
        if (frozen_o !== 1'b1) begin
            errors++;
            $display("FAIL halt_frozen: got %b expected 1", frozen_o);
        end
        repeat (50) drive(D0 | D1 | ST | FL | R0 | R1 | EN, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            rd(addrs[i], '0, d, v);
            checks++;
            if (v !== 1'b1 || d !== exps[i]) begin
                errors++;
                $display("FAIL halt_addr%0d: got %0d (vld %b) expected %0d", addrs[i], d, v, exps[i]);
            end
        end
        drive('0, 1'b0, 4'd0);
        checks++;
        if (rd_vld_o !== 1'b0 || rd_data_o !== 8'd3) begin
            errors++;
            $display("FAIL read_hold: got data=%0d vld=%b expected 3 0", rd_data_o, rd_vld_o);
        end
        rd(4'd2, CL, d, v);
        checks++;
        if (v !== 1'b1 || d !== 8'd3 || frozen_o !== 1'b0) begin
            errors++;
            $display("FAIL clr_read: got %0d (vld %b frozen %b) expected 3 (vld 1 frozen 0)", d, v, frozen_o);
        end
        for (int a = 0; a < 8; a++) begin
            rd(4'(a), '0, d, v);
            checks++;
            if (v !== 1'b1 || d !== 8'd0) begin
                errors++;
                $display("FAIL cleared_addr%0d: got %0d (vld %b) expected 0", a, d, v);
            end
        end
    endtask

    task automatic test_saturation();
        logic [W-1:0] d;
        logic v;
        logic [3:0]   addrs [5] = '{4'd2, 4'd2, 4'd2, 4'd1, 4'd0};
        logic [8:0]   evs   [5] = '{D0 | D1, D0 | D1, D0 | D1, 9'h000, 9'h000};
        logic [W-1:0] exps  [5] = '{8'd254, 8'd255, 8'd255, 8'd255, 8'd131};
        drive(CL, 1'b0, 4'd0);
        drive(EN, 1'b0, 4'd0);
        repeat (127) drive(D0 | D1, 1'b0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            rd(addrs[i], evs[i], d, v);
            checks++;
            if (v !== 1'b1 || d !== exps[i]) begin
                errors++;
                $display("FAIL sat_step%0d_addr%0d: got %0d (vld %b) expected %0d", i, addrs[i], d, v, exps[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] d;
        logic v;
        drive(CL, 1'b0, 4'd0);
        drive(EN, 1'b0, 4'd0);
        repeat (3) drive(D0 | D1, 1'b0, 4'd0);
        rd(4'd2, D0 | D1, d, v);
        checks++;
        if (v !== 1'b1 || d !== 8'd6) begin
            errors++;
            $display("FAIL pre_reset_read: got %0d (vld %b) expected 6", d, v);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_data_o !== '0 || rd_vld_o !== 1'b0 || frozen_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got data=%0d vld=%b frozen=%b expected 0 0 0", rd_data_o, rd_vld_o, frozen_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) drive(D0 | D1, 1'b0, 4'd0);
        rd(4'd2, '0, d, v);
        checks++;
        if (v !== 1'b1 || d !== 8'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %0d (vld %b) expected 0", d, v);
        end
        drive(EN, 1'b0, 4'd0);
        repeat (2) drive(D0 | D1, 1'b0, 4'd0);
        rd(4'd2, '0, d, v);
        checks++;
        if (v !== 1'b1 || d !== 8'd4) begin
            errors++;
            $display("FAIL resume_after_en: got %0d (vld %b) expected 4", d, v);
        end
    endtask

    initial begin
        test_reset();
        test_dual();
        test_backend();
        test_flush_derived();
        test_halt();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tma_event_counter.md
Name: tma_event_counter

Overview:
- Synthesizable top-down microarchitecture analysis (TMA) counter unit inside TinyCore.
- Taps the dual-slot decode/retire pipeline and accumulates per-slot event counts: instructions, frontend-bound, backend-bound, bubbles, retired, flushes.
- Sits directly downstream of the decoder and retire stage.
- Counts are read back through a registered read port, so benches and software no longer need hierarchical probes.

Parameters:
- CNT_W, 64: width of every counter.
- FLUSH_PENALTY, 4: refill cycles charged per flush cycle, per slot.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- en_i  in  1  start counting; sampled in IDLE
- clr_i  in  1  synchronous clear of all counters, returns FSM to IDLE
- halt_i  in  1  halt instruction decoded (decoder_valid and inst == 32'h0000_006b)
- dec0_vld_i  in  1  decode slot 0 valid
- dec1_vld_i  in  1  decode slot 1 valid
- backend_stall_i  in  1  backend stall this cycle
- flush_i  in  1  pipeline flush this cycle
- retire0_i  in  1  retire slot 0
- retire1_i  in  1  retire slot 1
- rd_en_i  in  1  read request
- rd_addr_i  in  4  counter select
- rd_data_o  out  CNT_W  read data
- rd_vld_o  out  1  read data valid
- frozen_o  out  1  counters frozen after halt

Behaviour:
- Reset: all counters 0, FSM in IDLE, rd_data_o=0, rd_vld_o=0, frozen_o=0.
- FSM transitions:
  - IDLE -> COUNT when en_i=1; counting starts the following cycle.
  - COUNT -> FROZEN when halt_i=1; that cycle's events are still counted.
  - FROZEN holds until clr_i=1.
  - clr_i=1 from any state -> IDLE with all counters 0.
  - clr_i has priority over all increments and over halt_i.
- Per COUNT cycle, for each slot s in {0,1}:
  - decs_vld=1: instr+=1, then backend+=1 if backend_stall_i, else frontend_raw+=1.
  - decs_vld=0: bubble+=1.
  - Per-cycle increments combine, so instr can rise by 0, 1 or 2.
- Also per COUNT cycle:
  - slots += 2 and cycles += 1.
  - flush_cyc += 1 if flush_i.
  - retired += retire0_i + retire1_i.
- Invariants in COUNT: slots == 2*cycles; instr + bubble == slots.
- Saturation: every counter saturates at all-ones and never wraps. A 2-increment from max-1 lands at max.
- Read addresses:
  - 0 cycles
  - 1 slots
  - 2 instr
  - 3 bubble
  - 4 frontend_raw
  - 5 backend
  - 6 retired
  - 7 flush_cyc
  - 8-11 see Optional Feature
  - others return 0
- Read timing:
  - Latency is 1 cycle: rd_vld_o=1 and rd_data_o valid the cycle after rd_en_i.
  - The value returned is the counter value before same-cycle increments.
  - rd_data_o holds its value while rd_vld_o=0.
- A read issued in the same cycle as clr_i returns the pre-clear value.
- In IDLE and FROZEN no counter changes; reads work in every state.
- Reset asserted mid-count clears everything immediately (asynchronous).

Optional Feature:
- Macro: TMA_DERIVED_EN.
- When defined, registered derived metrics are updated each cycle from the counter values:
  - addr 8 flush_recovery = flush_cyc*FLUSH_PENALTY*2
  - addr 9 frontend_bound = frontend_raw - flush_recovery, clamped to 0 if negative
  - addr 10 bad_spec = instr - retired, clamped to 0
  - addr 11 retired (alias)
- Derived values lag the counters by 1 cycle.
- When undefined, addresses 8-11 read 0 and no multiplier or subtractor logic is built.

Test Plan:
- Reset, en_i=1, then 10 cycles with dec0=dec1=1 and stall=0: read addr 2 -> 20, addr 4 -> 20, addr 1 -> 20, addr 3 -> 0.
- 6 cycles with dec0=1, dec1=0, stall=1: backend=6, bubble=6, instr=6, instr+bubble=slots=12.
- Flush 3 cycles, 30 instr, 25 retired, with TMA_DERIVED_EN: addr 8 -> 24, addr 10 -> 5. With frontend_raw=20, addr 9 -> 0 (clamped).
- halt_i pulse with dec0=1 in that cycle: that instr is counted, frozen_o=1 next cycle, and counters stay constant for 50 further active cycles. clr_i then gives all reads 0 and frozen_o=0.
- Force instr to max-1 (CNT_W=8: 254), then one dual-valid cycle: addr 2 -> 255; the next cycle stays 255.
- rst_n dropped mid-COUNT: outputs 0 without a clock edge; after release, counting does not resume until en_i=1.
